// File: rtl/step_sched_pkg.sv
// Shared definitions for the game-step scheduler: state encoding and
// default timing parameters.
package step_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_REQ   = 2'd2
  } state_e;

  localparam int BASE_TICKS_DEF = 50;
  localparam int STEP_TICKS_DEF = 3;
  localparam int MIN_TICKS_DEF  = 5;

endpackage

// File: rtl/step_sched_period_calc.sv
// Combinational speed-to-period mapping: max(MIN_TICKS, BASE_TICKS - speed*STEP_TICKS).
module step_period_calc
  import step_sched_pkg::*;
#(
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int STEP_TICKS = STEP_TICKS_DEF,
  parameter int MIN_TICKS  = MIN_TICKS_DEF
) (
  input  logic [3:0] speed_i,
  output logic [7:0] period_o
);

  // Wide enough that 15*255 cannot wrap, so any negative difference clamps.
  localparam logic signed [12:0] BASE_S = 13'(BASE_TICKS);
  localparam logic signed [12:0] STEP_S = 13'(STEP_TICKS);
  localparam logic signed [12:0] MIN_S  = 13'(MIN_TICKS);

  logic signed [12:0] diff;

  always_comb begin
    diff = BASE_S - ($signed({9'd0, speed_i}) * STEP_S);
    if (diff < MIN_S) begin
      period_o = 8'(MIN_S);
    end else begin
      period_o = 8'(diff);
    end
  end

endmodule

// File: rtl/step_sched.sv
// Game-step scheduler: issues a step request every P ticks and tracks
// requests that were not consumed in time.
module step_sched
  import step_sched_pkg::*;
#(
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int STEP_TICKS = STEP_TICKS_DEF,
  parameter int MIN_TICKS  = MIN_TICKS_DEF
) (
  input  logic        mclk,
  input  logic        clr_n,
  input  logic        tick_10ms,
  input  logic        run,
  input  logic [3:0]  speed,
  input  logic        step_ack,
  output logic        step_req,
  output logic [7:0]  overrun,
  output logic [15:0] step_cnt,
  output logic        active
);

  // state | meaning
  // IDLE  | stopped, cnt cleared
  // COUNT | counting ticks toward the next step
  // REQ   | step pending, counting continues

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  overrun_q, overrun_d;
  logic [15:0] step_cnt_q, step_cnt_d;
  logic        step_req_q, active_q;
  logic [7:0]  period;
  logic        expiry;

  step_period_calc #(
    .BASE_TICKS (BASE_TICKS),
    .STEP_TICKS (STEP_TICKS),
    .MIN_TICKS  (MIN_TICKS)
  ) u_period (
    .speed_i  (speed),
    .period_o (period)
  );

  assign expiry = tick_10ms && (cnt_q == 8'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    overrun_d  = overrun_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_COUNT;
          cnt_d   = period;
        end
      end
      ST_COUNT: begin
        if (!run) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (expiry) begin
          state_d    = ST_REQ;
          cnt_d      = period;
          step_cnt_d = step_cnt_q + 16'd1;
        end else if (tick_10ms) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_REQ: begin
        if (tick_10ms) begin
          cnt_d = expiry ? period : cnt_q - 8'd1;
        end
        // A stopped scheduler finishes its handshake and goes idle.
        if (step_ack && !run) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (step_ack && expiry) begin
          step_cnt_d = step_cnt_q + 16'd1;
        end else if (step_ack) begin
          state_d = ST_COUNT;
        end else if (expiry && (overrun_q != 8'hFF)) begin
          overrun_d = overrun_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      overrun_q  <= 8'd0;
      step_cnt_q <= 16'd0;
      step_req_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      step_cnt_q <= step_cnt_d;
      step_req_q <= (state_d == ST_REQ);
      active_q   <= (state_d != ST_IDLE);
    end
  end

  assign step_req = step_req_q;
  assign overrun  = overrun_q;
  assign step_cnt = step_cnt_q;
  assign active   = active_q;

endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: period table plus handshake, overrun,
// stop and reset sequences.
module tb_step_sched;

  logic        mclk = 1'b0;
  logic        clr_n;
  logic        tick_10ms;
  logic        run;
  logic [3:0]  speed;
  logic        step_ack;
  logic        step_req, step_req2;
  logic [7:0]  overrun, overrun2;
  logic [15:0] step_cnt, step_cnt2;
  logic        active, active2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 mclk = ~mclk;

  step_sched dut (
    .mclk(mclk), .clr_n(clr_n), .tick_10ms(tick_10ms), .run(run),
    .speed(speed), .step_ack(step_ack), .step_req(step_req),
    .overrun(overrun), .step_cnt(step_cnt), .active(active)
  );

  step_sched #(.MIN_TICKS(10)) dut_min10 (
    .mclk(mclk), .clr_n(clr_n), .tick_10ms(tick_10ms), .run(run),
    .speed(speed), .step_ack(step_ack), .step_req(step_req2),
    .overrun(overrun2), .step_cnt(step_cnt2), .active(active2)
  );

  typedef struct {
    logic [3:0] spd;
    int         exp_p;
    int         exp_p10;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick_10ms = 1'b1;
    repeat (n) step();
    tick_10ms = 1'b0;
  endtask

  task automatic do_reset();
    clr_n = 1'b0; run = 1'b0; tick_10ms = 1'b0; step_ack = 1'b0; speed = 4'd0;
    step();
    clr_n = 1'b1;
  endtask

  initial begin
    int got1, got2, ntick, ack_at, rise_n;
    int rise_tick [2];
    int rise_cnt  [2];
    int rise_ovr  [2];
    logic prev;

    vecs[0] = '{4'd0,  50, 50};
    vecs[1] = '{4'd1,  47, 47};
    vecs[2] = '{4'd5,  35, 35};
    vecs[3] = '{4'd10, 20, 20};
    vecs[4] = '{4'd14,  8, 10};
    vecs[5] = '{4'd15,  5, 10};

    // Reset state, checked asynchronously before any clock edge.
    clr_n = 1'b1; run = 1'b0; tick_10ms = 1'b0; step_ack = 1'b0; speed = 4'd0;
    #2;
    clr_n = 1'b0;
    #1;
    chk("reset_req", int'(step_req), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_cnt", int'(step_cnt), 0);
    step();
    clr_n = 1'b1;

    // Period table: ticks every cycle, count ticks until step_req rises.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      speed = vecs[v].spd;
      run = 1'b1;
      step();
      got1 = -1; got2 = -1;
      tick_10ms = 1'b1;
      for (int k = 1; k <= 300 && (got1 < 0 || got2 < 0); k++) begin
        step();
        if (got1 < 0 && step_req)  got1 = k;
        if (got2 < 0 && step_req2) got2 = k;
      end
      tick_10ms = 1'b0;
      chk($sformatf("period_spd%0d", vecs[v].spd), got1, vecs[v].exp_p);
      chk($sformatf("period_min10_spd%0d", vecs[v].spd), got2, vecs[v].exp_p10);
    end

    // Cadence at speed 0, tick every 10 cycles, ack 2 cycles after each request.
    do_reset();
    run = 1'b1;
    step();
    ntick = 0; ack_at = -1; rise_n = 0; prev = 1'b0;
    rise_tick[0] = -1; rise_tick[1] = -1;
    rise_cnt[0] = -1;  rise_cnt[1] = -1;
    rise_ovr[0] = -1;  rise_ovr[1] = -1;
    for (int c = 0; c < 1200 && rise_n < 2; c++) begin
      tick_10ms = (c % 10 == 9);
      step_ack  = (c == ack_at);
      step();
      if (tick_10ms) ntick++;
      if (step_req && !prev) begin
        rise_tick[rise_n] = ntick;
        rise_cnt[rise_n]  = int'(step_cnt);
        rise_ovr[rise_n]  = int'(overrun);
        rise_n++;
        ack_at = c + 2;
      end
      prev = step_req;
    end
    tick_10ms = 1'b0; step_ack = 1'b0;
    chk("cadence_rise1_tick", rise_tick[0], 50);
    chk("cadence_rise1_cnt", rise_cnt[0], 1);
    chk("cadence_rise1_ovr", rise_ovr[0], 0);
    chk("cadence_rise2_tick", rise_tick[1], 100);
    chk("cadence_rise2_cnt", rise_cnt[1], 2);

    // Ack withheld for three further periods (speed 15, P=5).
    do_reset();
    speed = 4'd15; run = 1'b1;
    step();
    ticks(20);
    chk("withheld_req", int'(step_req), 1);
    chk("withheld_ovr", int'(overrun), 3);
    chk("withheld_cnt", int'(step_cnt), 1);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    chk("ack_req_low", int'(step_req), 0);
    chk("ack_active", int'(active), 1);

    // Ack coincident with expiry.
    ticks(5);
    chk("req2_req", int'(step_req), 1);
    chk("req2_cnt", int'(step_cnt), 2);
    ticks(4);
    tick_10ms = 1'b1; step_ack = 1'b1;
    step();
    tick_10ms = 1'b0; step_ack = 1'b0;
    chk("coinc_req", int'(step_req), 1);
    chk("coinc_cnt", int'(step_cnt), 3);
    chk("coinc_ovr", int'(overrun), 3);

    // Stop in COUNT, ticks ignored in IDLE, stop in REQ held until ack.
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    run = 1'b0;
    step();
    chk("stop_count_active", int'(active), 0);
    ticks(10);
    chk("idle_ticks_active", int'(active), 0);
    chk("idle_ticks_cnt", int'(step_cnt), 3);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    chk("idle_ack_ignored_req", int'(step_req), 0);
    run = 1'b1;
    step();
    ticks(5);
    chk("restart_req", int'(step_req), 1);
    run = 1'b0;
    repeat (3) step();
    chk("stop_req_held", int'(step_req), 1);
    chk("stop_req_active", int'(active), 1);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    chk("stop_ack_req", int'(step_req), 0);
    chk("stop_ack_active", int'(active), 0);

    // Overrun saturation, then asynchronous reset mid-REQ.
    do_reset();
    speed = 4'd15; run = 1'b1;
    step();
    ticks(5 * 256);
    chk("sat_ovr", int'(overrun), 255);
    ticks(5);
    chk("sat_ovr_hold", int'(overrun), 255);
    chk("sat_cnt", int'(step_cnt), 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_req", int'(step_req), 0);
    chk("async_ovr", int'(overrun), 0);
    chk("async_cnt", int'(step_cnt), 0);
    chk("async_active", int'(active), 0);
    step();
    clr_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
